// File: rtl/cnt_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch control front-end.
// The controller takes the slave side; whoever drives the buttons takes the master side.
interface cnt_ctrl_if;
    logic btn_start_stop;
    logic btn_clear;
    logic enable;
    logic clear;
    logic running;
    logic paused;

    modport slave (
        input  btn_start_stop,
        input  btn_clear,
        output enable,
        output clear,
        output running,
        output paused
    );

    modport master (
        output btn_start_stop,
        output btn_clear,
        input  enable,
        input  clear,
        input  running,
        input  paused
    );
endinterface

// File: rtl/cnt_ctrl.sv
// Stopwatch control front-end: synchronises and debounces two push-buttons, runs an
// IDLE/RUN/PAUSE machine and a prescaler, and emits one-cycle enable/clear pulses.
module cnt_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int PRESCALE  = 1000
) (
    input  logic       clk,
    input  logic       res_n,
    cnt_ctrl_if.slave  ctrl
);
    localparam int DB_W = ($clog2(DB_CYCLES) > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PS_W = ($clog2(PRESCALE) > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Bit 0 is start/stop, bit 1 is clear.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {ctrl.btn_clear, ctrl.btn_start_stop};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            deb_q;
        logic            deb_d;
        logic            deb_prev_q;
        logic            press_q;
        logic            press_d;
        logic [DB_W-1:0] cnt_q;
        logic [DB_W-1:0] cnt_d;

        // Any cycle where the synced level agrees with the debounced one restarts the count.
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == DB_MAX) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            press_d = deb_q & ~deb_prev_q;
        end

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
                press_q    <= 1'b0;
            end else begin
                sync1_q    <= btn_raw[gi];
                sync2_q    <= sync1_q;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                cnt_q      <= cnt_d;
                press_q    <= press_d;
            end
        end

        assign press[gi] = press_q;
    end

    logic            ss_press;
    logic            clr_press;
    state_t          state_q;
    state_t          state_d;
    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic            run_cont;
    logic            enable_q;
    logic            enable_d;
    logic            clear_q;
    logic            clear_d;
    logic            running_q;
    logic            running_d;
    logic            paused_q;
    logic            paused_d;

    assign ss_press  = press[0];
    assign clr_press = press[1];

    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = S_IDLE;
        end else if (ss_press) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end

        // Only cycles spent in RUN on both sides of the edge advance the prescaler, so a
        // pause or clear never lands an enable in a non-RUN cycle.
        run_cont = (state_q == S_RUN) && (state_d == S_RUN);

        ps_d = ps_q;
        if (clr_press) begin
            ps_d = '0;
        end else if (run_cont) begin
            ps_d = (ps_q == PS_MAX) ? '0 : ps_q + 1'b1;
        end

        enable_d  = run_cont && (ps_q == PS_MAX);
        clear_d   = clr_press;
        running_d = (state_d == S_RUN);
        paused_d  = (state_d == S_PAUSE);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= S_IDLE;
            ps_q      <= '0;
            enable_q  <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            enable_q  <= enable_d;
            clear_q   <= clear_d;
            running_q <= running_d;
            paused_q  <= paused_d;
        end
    end

    assign ctrl.enable  = enable_q;
    assign ctrl.clear   = clear_q;
    assign ctrl.running = running_q;
    assign ctrl.paused  = paused_q;
endmodule
